branch_predictor_table: RTL



---
 rtl/branch_predictor_table_pkg.sv | 27 ++
 rtl/branch_predictor_table_sat_counter.sv | 19 +
 rtl/branch_predictor_table.sv | 80 ++++++++
 3 files changed

// File: rtl/branch_predictor_table_pkg.sv
// Shared encodings and the saturating-counter step for the branch predictor table.
package bp_pkg;

  // Widest counter the shared helper supports; per-entry widths are narrower slices.
  localparam int unsigned CNT_MAX_W = 8;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } cnt2_e;

  function automatic logic [CNT_MAX_W-1:0] sat_next(
    input logic [CNT_MAX_W-1:0] cnt,
    input int unsigned          w,
    input logic                 taken
  );
    logic [CNT_MAX_W:0]   one_sh;
    logic [CNT_MAX_W-1:0] max_v;
    one_sh = (CNT_MAX_W+1)'(1) << w;
    max_v  = CNT_MAX_W'(one_sh - (CNT_MAX_W+1)'(1));
    if (taken) return (cnt >= max_v) ? max_v : cnt + CNT_MAX_W'(1);
    else       return (cnt == '0)    ? '0    : cnt - CNT_MAX_W'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_table_sat_counter.sv
// Combinational next state for one CNT_W-bit saturating counter.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             taken_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_MAX_W-1:0] nxt_wide;

  always_comb begin
    nxt_wide = sat_next(CNT_MAX_W'(cnt_i), CNT_W, taken_i);
    cnt_o    = nxt_wide[CNT_W-1:0];
  end

endmodule

// File: rtl/branch_predictor_table.sv
// Branch history table of saturating counters: registered lookup, execute-side training,
// single-cycle flush and a saturating mispredict counter.
module branch_predictor_table
  import bp_pkg::*;
#(
  parameter int unsigned IDX_W    = 5,
  parameter int unsigned CNT_W    = 2,
  parameter int unsigned INIT_CNT = 1,
  parameter int unsigned STAT_W   = 16
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              lookup_en,
  input  logic [IDX_W-1:0]  lookup_idx,
  output logic              pred_taken,
  output logic              pred_valid,
  input  logic              upd_en,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  input  logic              flush,
  output logic [STAT_W-1:0] mispredict_cnt
);

  localparam int unsigned DEPTH = 2 ** IDX_W;
  localparam logic [CNT_W-1:0] INIT_V = CNT_W'(INIT_CNT);

  logic [CNT_W-1:0]  table_q [DEPTH];
  logic [CNT_W-1:0]  table_d [DEPTH];
  logic              pred_taken_q, pred_taken_d;
  logic              pred_valid_q, pred_valid_d;
  logic [STAT_W-1:0] mis_q, mis_d;
  logic [CNT_W-1:0]  upd_nxt;

  bp_sat_counter #(.CNT_W(CNT_W)) u_sat (
    .cnt_i  (table_q[upd_idx]),
    .taken_i(upd_taken),
    .cnt_o  (upd_nxt)
  );

  // Lookup reads table_q, so a same-cycle update or flush is never bypassed.
  always_comb begin
    pred_valid_d = lookup_en;
    pred_taken_d = lookup_en ? table_q[lookup_idx][CNT_W-1] : pred_taken_q;
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) table_d[i] = table_q[i];
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) table_d[i] = INIT_V;
    end else if (upd_en) begin
      table_d[upd_idx] = upd_nxt;
    end
  end

  // Counted even when a flush discards the update.
  always_comb begin
    mis_d = mis_q;
    if (upd_en && (upd_pred != upd_taken) && (mis_q != '1)) mis_d = mis_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!arst_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= INIT_V;
      pred_taken_q <= 1'b0;
      pred_valid_q <= 1'b0;
      mis_q        <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= table_d[i];
      pred_taken_q <= pred_taken_d;
      pred_valid_q <= pred_valid_d;
      mis_q        <= mis_d;
    end
  end

  assign pred_taken     = pred_taken_q;
  assign pred_valid     = pred_valid_q;
  assign mispredict_cnt = mis_q;

endmodule
